// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan controller: blank code,
// sequencer state encoding and an index-width helper.
package display_pkg;

  // BCD code the downstream decoder turns into "all segments off".
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  // Bits needed to count/index 0..n-1; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3, one input bit per clock).
// Carries out of the top nibble are folded into a sticky overflow flag.
module bin2bcd_serial
  import display_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = idx_width(DATA_W + 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Datapath next state: capture on start, otherwise adjust-and-shift while bits remain.
  // NOTE: every variable gets a default before any branch so no latch can be inferred.
  always_comb begin
    adj   = bcd_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      bin_d = value_i;
      bcd_d = '0;
      ovf_d = 1'b0;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      bin_d = bin_q << 1;
      bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
      // The bit leaving the top nibble is a carry into a digit we do not have.
      ovf_d = ovf_q | adj[BCD_W-1];
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers.
  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  // High during the clock whose edge performs the final shift.
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 7-segment display sequencer: load/busy handshake into a serial BCD
// converter, atomic commit into digit registers, and a free-running scan
// that multiplexes one digit at a time onto the shared decoder.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int SCAN_W = idx_width(SCAN_DIV);

  state_e state_q, state_d;

  logic             conv_start, conv_busy, conv_done, conv_ovf, commit;
  logic [BCD_W-1:0] conv_bcd;

  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic                       ovf_q, done_q;

  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  bin2bcd_serial #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .value_i (value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Sequencer next state; a converter that went idle mid-conversion drops back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load) state_d = S_CONVERT;
      S_CONVERT: begin
        if (conv_done)       state_d = S_COMMIT;
        else if (!conv_busy) state_d = S_IDLE;
      end
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs: loads are accepted only from IDLE.
  always_comb begin
    busy       = (state_q != S_IDLE);
    conv_start = (state_q == S_IDLE) && load;
    commit     = (state_q == S_COMMIT);
  end

  // Digit registers and status, updated only at commit so partial results never show.
  // NOTE: the digit bank is reset because the display must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        ovf_q   <= conv_ovf;
        digit_q <= conv_ovf ? {NUM_DIGITS{BCD_BLANK}} : conv_bcd;
      end
    end
  end

  // Scan divider and digit index next state; runs regardless of sequencer state.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leading-zero blanking (blank_lz is used live) and one-hot-low enable for the current digit.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (digit_q[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (digit_q[i] == 4'd0);
    end
    bcd_out_d = digit_q[idx_q];
    if ((idx_q != '0) && blank_lz && upper_zero[idx_q]) bcd_out_d = BCD_BLANK;
    digit_en_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  // Scan registers; bcd_out and digit_en change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q     <= '0;
      idx_q      <= '0;
      bcd_out_q  <= BCD_BLANK;
      digit_en_q <= '1;
    end else begin
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      bcd_out_q  <= bcd_out_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_out_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short scan period.
module tb_display_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = 14;
  localparam int SCAN_DIV   = 4;

  logic                  clk;
  logic                  rst;
  logic                  load;
  logic [DATA_W-1:0]     value;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [3:0]            bcd_out;
  logic [NUM_DIGITS-1:0] digit_en;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  display_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load v, expect busy for 15 cycles then a done cycle with the given overflow.
  task automatic run_conv(input logic [DATA_W-1:0] v, input logic exp_ovf, input string tag);
    int busy_cycles;
    busy_cycles = 0;
    @(posedge clk); #1 value = v; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b0) busy_cycles++;
    end
    check({tag, " busy len"}, busy_cycles, 15);
    @(negedge clk);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy end"}, busy, 1'b0);
    check({tag, " ovf"}, overflow, exp_ovf);
  endtask

  // Sync to the start of a digit-0 window, then check each digit's code, enable and dwell.
  task automatic check_scan(input logic [15:0] exp, input string tag);
    logic [3:0] prev;
    logic [3:0] mask;
    int         n;
    bit         found;
    found = 1'b0;
    prev  = digit_en;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (digit_en == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = digit_en;
    end
    check({tag, " sync"}, found, 1'b1);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      mask = ~(4'b0001 << d);
      check($sformatf("%s en%0d", tag, d), digit_en, mask);
      check($sformatf("%s bcd%0d", tag, d), bcd_out, exp[4*d +: 4]);
      n = 1;
      @(negedge clk);
      while (digit_en == mask && n < 8) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("%s dwell%0d", tag, d), n, SCAN_DIV);
    end
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;

    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;

    // 1: reset values, release mid-clock, async assertion
    @(negedge clk);
    check("rst bcd", bcd_out, 4'hF);
    check("rst en", digit_en, 4'hF);
    check("rst busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rel en", digit_en, 4'b1110);
    check("rel bcd", bcd_out, 4'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async bcd", bcd_out, 4'hF);
    check("async en", digit_en, 4'hF);
    check("async done", done, 1'b0);
    check("async ovf", overflow, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rel2 en", digit_en, 4'b1110);
    check("rel2 bcd", bcd_out, 4'h0);

    // 2: 1234 with latency and scan order
    run_conv(14'd1234, 1'b0, "t2");
    check_scan(16'h1234, "t2 scan");

    // 3: leading-zero blanking, sampled live
    run_conv(14'd7, 1'b0, "t3");
    blank_lz = 1'b1;
    check_scan(16'hFFF7, "t3 blank");
    blank_lz = 1'b0;
    check_scan(16'h0007, "t3 noblank");

    // 4: overflow boundary
    run_conv(14'd10000, 1'b1, "t4 ovf");
    check_scan(16'hFFFF, "t4 scan");
    check("t4 ovf held", overflow, 1'b1);
    run_conv(14'd9999, 1'b0, "t4 max");
    check_scan(16'h9999, "t4 scan max");

    // 5: loads at edges N+3, N+14, N+15 ignored; load at N+16 (done cycle) accepted
    ndone = 0; first_done = -1; second_done = -1;
    @(posedge clk); #1 value = 14'd4321; load = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      @(posedge clk);
      #1;
      load  = ((c + 1) == 3) || ((c + 1) >= 14 && (c + 1) <= 16);
      value = ((c + 1) == 16) ? 14'd55 : 14'd1111;
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c == 16) check("t5 reload busy", busy, 1'b1);
    end
    check("t5 done count", ndone, 2);
    check("t5 first done", first_done, 15);
    check("t5 second done", second_done, 31);
    check_scan(16'h0055, "t5 scan");

    // 6: reset mid-conversion aborts and clears display
    @(posedge clk); #1 value = 14'd5678; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst bcd", bcd_out, 4'hF);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("t6 no done", ndone, 0);
    check_scan(16'h0000, "t6 scan");
    run_conv(14'd42, 1'b0, "t6 next");
    check_scan(16'h0042, "t6 scan next");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
